// File: rtl/aoc_common_pkg.sv
// Shared arbitration types and the round-robin search helper used by the
// puzzle-input readers.
package aoc_common_pkg;

  typedef enum logic {ARB, LOCK} arb_state_t;

  localparam int RR_MAX = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of mask scanning from last+1 upward, wrapping at n.
  function automatic rr_pick_t rr_next(input logic [RR_MAX-1:0] mask,
                                       input int last, input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n && !r.found) begin
        j = last + k;
        if (j >= n) j = j - n;
        if (mask[j[4:0]]) begin
          r.found = 1'b1;
          r.idx   = j[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester, response and ROM-head signals of the shared ROM read port.
interface rom_read_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 16,
  parameter int REQS      = 4
);
  logic [REQS-1:0]                req_valid;
  logic [REQS-1:0]                req_lock;
  logic [REQS-1:0][ADDR_BITS-1:0] req_addr;
  logic [REQS-1:0]                req_ready;
  logic [REQS-1:0]                resp_valid;
  logic [REQS-1:0][DATA_BITS-1:0] resp_data;
  logic [ADDR_BITS-1:0]           rom_addr;
  logic [DATA_BITS-1:0]           rom_data;

  modport master (
    output req_valid, req_lock, req_addr, rom_data,
    input  req_ready, resp_valid, resp_data, rom_addr
  );

  modport slave (
    input  req_valid, req_lock, req_addr, rom_data,
    output req_ready, resp_valid, resp_data, rom_addr
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
module rr_priority_pick
  import aoc_common_pkg::*;
#(
  parameter int REQS = 4
) (
  input  logic [REQS-1:0]         mask,
  input  logic [$clog2(REQS)-1:0] last,
  output logic                    found,
  output logic [$clog2(REQS)-1:0] idx
);
  rr_pick_t pick;

  always_comb begin
    pick  = rr_next(RR_MAX'(mask), int'(last), REQS);
    found = pick.found;
    idx   = pick.idx[$clog2(REQS)-1:0];
  end
endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read head, with bounded
// lock bursts and registered one-cycle-latency responses.
module rom_read_arbiter
  import aoc_common_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 16,
  parameter int REQS      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  rom_read_arbiter_if.slave  bus
);
  localparam int PW = $clog2(REQS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_t      state, state_n;
  logic [PW-1:0]   last_grant, last_n;
  logic [PW-1:0]   owner, owner_n;
  logic [BW-1:0]   burst_cnt, burst_n;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic            gnt;
  logic [PW-1:0]   g;
  logic [REQS-1:0] grant_vec;

  rr_priority_pick #(.REQS(REQS)) u_pick (
    .mask  (bus.req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    last_n  = last_grant;
    owner_n = owner;
    burst_n = burst_cnt;
    gnt     = 1'b0;
    g       = owner;
    case (state)
      ARB: begin
        if (pick_found) begin
          gnt    = 1'b1;
          g      = pick_idx;
          last_n = pick_idx;
          if (bus.req_lock[pick_idx] && MAX_BURST > 1) begin
            state_n = LOCK;
            owner_n = pick_idx;
            burst_n = BW'(1);
          end
        end
      end
      LOCK: begin
        // Owner dropping valid or ending its burst both hand rotation to owner+1.
        if (bus.req_valid[owner]) begin
          gnt = 1'b1;
          if (bus.req_lock[owner] && burst_cnt < BURST_LAST) begin
            burst_n = burst_cnt + 1'b1;
          end else begin
            state_n = ARB;
            last_n  = owner;
            burst_n = '0;
          end
        end else begin
          state_n = ARB;
          last_n  = owner;
          burst_n = '0;
        end
      end
      default: state_n = ARB;
    endcase
    if (rst) gnt = 1'b0;
    grant_vec     = gnt ? (REQS'(1) << g) : '0;
    bus.req_ready = grant_vec;
    bus.rom_addr  = gnt ? bus.req_addr[g] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ARB;
      last_grant     <= PW'(REQS - 1);
      owner          <= '0;
      burst_cnt      <= '0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
    end else begin
      state          <= state_n;
      last_grant     <= last_n;
      owner          <= owner_n;
      burst_cnt      <= burst_n;
      bus.resp_valid <= grant_vec;
      if (gnt) bus.resp_data[g] <= bus.rom_data;
    end
  end
endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one read head of a puzzle-input ROM between REQS requesters, e.g. parser stages of a day's solver.
- The ROM head is combinational. The arbiter grants one requester per cycle round-robin, drives the ROM address, and returns registered data one cycle later to the granted requester.
- Optional lock lets a requester stream consecutive reads, bounded by MAX_BURST to prevent starvation.

Parameters:
- DATA_BITS, 8: ROM data width.
- ADDR_BITS, 16: ROM address width.
- REQS, 4: number of requesters; must be >= 2.
- MAX_BURST, 16: maximum consecutive locked grants before forced rotation; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  [REQS]  requester i has a read pending.
- req_lock  in  [REQS]  requester i asks to keep the grant after this read.
- req_addr  in  [REQS][ADDR_BITS]  read address from requester i.
- req_ready  out  [REQS]  one-hot or zero; a read is accepted when req_valid[i] & req_ready[i].
- resp_valid  out  [REQS]  one-cycle pulse carrying the response for requester i.
- resp_data  out  [REQS][DATA_BITS]  response data, meaningful only while resp_valid[i] is high.
- rom_addr  out  ADDR_BITS  address driven to the ROM head.
- rom_data  in  DATA_BITS  combinational ROM output for rom_addr. Out-of-range addresses return 0; the arbiter does not check range.

Behaviour:
- Reset (asynchronous, immediate):
  - resp_valid = 0, resp_data = 0, last_grant = REQS-1 (requester 0 has top priority first), state = ARB, burst_cnt = 0.
  - req_ready = 0 while rst is high.
- States:
  - ARB: the grant goes to the first i with req_valid[i], scanning from last_grant+1 upward with wrap modulo REQS.
  - LOCK: the grant stays on lock_owner. Other requesters get no grant that cycle.
- Grant and ROM address:
  - req_ready is combinational from req_valid, state and pointers. At most one bit is high; none are high if no eligible request exists.
  - rom_addr = req_addr[g] when a grant exists, otherwise 0.
- Response, latency 1:
  - On an accepted cycle, at the next edge resp_valid[g] <= 1 and resp_data[g] <= rom_data. All other resp_valid bits go to 0.
  - Non-accepted edges clear all resp_valid bits. resp_data holds its last value.
  - Responses have no backpressure.
  - Throughput is 1 read per cycle in total.
- Transitions:
  - ARB → LOCK: accepted grant to g with req_lock[g]=1 and MAX_BURST > 1. Sets lock_owner = g, burst_cnt = 1.
  - ARB → ARB: all other cases. Any grant sets last_grant = g.
  - LOCK, owner valid & lock & burst_cnt < MAX_BURST-1: accept, burst_cnt += 1, stay in LOCK.
  - LOCK, owner valid & (!lock or burst_cnt == MAX_BURST-1): accept this final read, last_grant = owner, return to ARB.
  - LOCK, owner req_valid low: no grant that cycle, return to ARB. Next-cycle arbitration starts after the owner.
- Forced release: after MAX_BURST consecutive locked grants, the next cycle arbitrates in ARB with the owner lowest priority. If no one else is requesting, the owner may re-win and re-lock.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - Pointers are $clog2(REQS) bits. Wrap is explicit (REQS need not be a power of two).
- Simultaneous events:
  - A requester whose response pulse is high may be granted again in the same cycle.
  - req_lock is sampled only on accepted cycles.
- Reset mid-operation: in-flight responses are dropped (no pulse after release). Lock and burst state are discarded.

Decomposition:
- Shared package aoc_common_pkg:
  - arb_state_t enum {ARB, LOCK}.
  - Function rr_next(mask, last, n) returning the index and a found flag.
- One sub-module is natural: rr_priority_pick, the combinational round-robin picker parameterised on REQS. It is reusable by other arbiters in the codebase.
- The top level holds the FSM, burst counter, and response registers.

Test Plan (ROM image data[a] = a[7:0] ^ 8'h5A, DATA_BITS=8, REQS=4, MAX_BURST=4):
- Reset release, then req_valid=4'b0001, addr0=16'h0003 → req_ready=4'b0001 in the same cycle; next cycle resp_valid=4'b0001, resp_data[0]=8'h59.
- All four requesters valid continuously, no lock → grants in the order 0,1,2,3,0,… with one resp pulse per cycle. Responses go to 0..3 with data matching the addresses.
- Requester 2 locked with addrs 10,11,12,…, others valid → 4 consecutive grants to 2 (data 8'h50,8'h51,8'h56,8'h57), then grant to 3, then 0.
- Requester 1 locks, then drops req_valid after 2 reads while requester 0 waits → one idle-grant cycle (req_ready=0), then grant to 2 if valid, else 3, else 0. No stale resp pulse.
- Address 16'hFFFF with the ROM shorter than that → resp_data=8'h00, resp_valid pulse still produced.
- Assert rst in the cycle after an accepted read → resp_valid stays 0 and never pulses. After release, requester 0 has top priority.
